axi_instr_fetch_bridge: RTL and testbench
=========================================

# axi_instr_fetch_bridge

Converts the core's instruction-fetch request/grant/rvalid interface into single-beat AXI4 read transactions toward the instruction-memory AXI slave (the instruction AXI VIP in `axi_verifier`). It sits directly upstream of that slave and owns the AR/R channels only. It supports up to `MAX_OUTSTANDING` in-order fetches in flight and flags error responses back to the core.

## Interface
- `MAX_OUTSTANDING`, 2: maximum granted-but-unanswered fetches. Range 1..4.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32.
- `clk` in 1: single clock, 100 MHz in `axi_verifier`.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `instr_req_i` in 1: core fetch request.
- `instr_addr_i` in ADDR_W: fetch address.
- `instr_gnt_o` out 1: request accepted this cycle.
- `instr_rvalid_o` out 1: fetch data valid, one cycle pulse per grant.
- `instr_rdata_o` out DATA_W: fetched word.
- `instr_err_o` out 1: qualifies `instr_rvalid_o`; response was SLVERR or DECERR.
- `m_axi_araddr` out ADDR_W, `m_axi_arvalid` out 1, `m_axi_arready` in 1, `m_axi_arprot` out 3, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2: AXI4 read address channel.
- `m_axi_rdata` in DATA_W, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI4 read data channel.
- `err_valid_o` out 1, `err_addr_o` out ADDR_W, `err_resp_o` out 2, `err_clear_i` in 1: error capture. Present only with the macro (see Configuration).

## Operation
- AR FSM states:
  - IDLE: `arvalid`=0.
  - AR_PEND: `arvalid`=1, `araddr`/`arprot` held stable.
- `instr_gnt_o` = `instr_req_i` && (state==IDLE || AR handshake this cycle) && (`outstanding` < MAX_OUTSTANDING || R handshake this cycle). This is combinational.
- On grant, the next state is AR_PEND and `araddr` is registered as {`instr_addr_i`[ADDR_W-1:2], 2'b00}. Misaligned addresses are silently aligned.
- AR_PEND → IDLE on `arready`, unless a new grant happens in the same cycle; then the state stays in AR_PEND with the new address (back-to-back issue).
- Constants: `arlen`=0, `arsize`=3'b010, `arburst`=INCR, `arprot`=3'b100 (instruction, secure, unprivileged).
- `outstanding` is a counter of width clog2(MAX_OUTSTANDING+1).
  - +1 on grant, −1 on R handshake.
  - Grant and R handshake in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- `m_axi_rready` = (`outstanding` != 0). An R beat arriving with `outstanding`==0 is not accepted.
- On R handshake:
  - `instr_rvalid_o`, `instr_rdata_o` and `instr_err_o` = (`rresp[1]`) are registered and appear the following cycle.
  - `rlast` is ignored (single beat).
- Responses are returned strictly in grant order. No reordering; AXI in-order is relied upon.

## Timing
- Reset values: `instr_gnt_o` 0, `instr_rvalid_o` 0, `instr_rdata_o` 0, `instr_err_o` 0, `m_axi_arvalid` 0, `m_axi_araddr` 0, `m_axi_rready` 0, `outstanding` 0, FSM IDLE, `err_*` 0.
- Best-case latency:
  - Grant in cycle N.
  - `arvalid` in N+1.
  - Slave returns `rvalid` in N+2 at the earliest.
  - `instr_rvalid_o` in N+3.
- Throughput: one grant per cycle while `arready` is held high and `outstanding` is below the limit.
- `arvalid` is never deasserted without `arready`.
- Reset mid-transaction discards all in-flight state. The bench must not return stale R beats after reset.

## Configuration
- `KUUGA_FETCH_ERR_CAPTURE_EN` defined:
  - Instantiates an address FIFO (depth MAX_OUTSTANDING) written on grant and popped on R handshake.
  - On the first error response while `err_valid_o`=0, latches `err_addr_o` and `err_resp_o` and sets `err_valid_o`. The flag is sticky.
  - `err_clear_i` clears `err_valid_o` the next cycle. If a new error arrives in the same cycle, the new error wins.
- Undefined: no FIFO and no capture logic. `err_*` outputs are tied to 0 and `err_clear_i` is ignored. `instr_err_o` still works.

## Structure
- Shared package `kuuga_axi_pkg`:
  - `axi_resp_e` (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
  - `AXI_BURST_INCR`, `AXI_ARPROT_INSTR`, `AXI_SIZE_4B`.
- Sub-module `fetch_addr_fifo`: parameterised depth/width synchronous FIFO with `full`/`empty`. Used only under the macro.

## Test plan
- Single fetch: req with addr 0x80; slave memory 0x80 = 0xF81FF06F, `arready` and `rvalid` immediate → `araddr`=0x80 in cycle N+1; `instr_rvalid_o` with rdata 0xF81FF06F in N+3; exactly one pulse.
- Back-to-back: req held for addrs 0x80, 0x84, 0x88 with MAX_OUTSTANDING=2 and `rvalid` delayed 5 cycles → the third grant is withheld until the first R handshake; data returns in order.
- AR backpressure: `arready` low for 4 cycles → `arvalid` and `araddr` stay stable; no grant while in AR_PEND without handshake.
- Misaligned: addr 0x83 → `araddr` 0x80.
- Error: `rresp`=SLVERR on addr 0x100 → `instr_err_o`=1 with `instr_rvalid_o`; with the macro, `err_addr_o`=0x100 and `err_resp_o`=2 stay sticky through a second error until `err_clear_i`.
- Reset mid-flight: `rst_n` low with 2 outstanding → all outputs return to reset values immediately; after release, a fresh fetch to 0x80 completes normally.

Source files
------------

// File: rtl/kuuga_axi_pkg.sv
// Shared AXI4 constants and types for the kuuga instruction-fetch path.
package kuuga_axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [2:0] AXI_ARPROT_INSTR = 3'b100;
  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
  localparam logic [7:0] AXI_LEN_SINGLE   = 8'd0;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_PEND = 1'b1
  } ar_state_e;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/fetch_addr_fifo.sv
// Small synchronous FIFO holding the addresses of in-flight fetches.
// A push is accepted while full when a pop happens in the same cycle.
module fetch_addr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/axi_instr_fetch_bridge.sv
// Core instruction-fetch req/gnt/rvalid to single-beat AXI4 AR/R bridge.
// Optional error address capture: define KUUGA_FETCH_ERR_CAPTURE_EN.
module axi_instr_fetch_bridge
  import kuuga_axi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 instr_req_i,
  input  logic [ADDR_W-1:0]                    instr_addr_i,
  output logic                                 instr_gnt_o,
  output logic                                 instr_rvalid_o,
  output logic [DATA_W-1:0]                    instr_rdata_o,
  output logic                                 instr_err_o,
  output logic [ADDR_W-1:0]                    m_axi_araddr,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  output logic [2:0]                           m_axi_arprot,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  output logic [1:0]                           m_axi_arburst,
  input  logic [DATA_W-1:0]                    m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rlast,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  output logic                                 err_valid_o,
  output logic [ADDR_W-1:0]                    err_addr_o,
  output logic [1:0]                           err_resp_o,
  input  logic                                 err_clear_i,
  output logic                                 dbg_ar_state_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; once raised, valid holds its payload
  // stable until that edge. instr_gnt_o is the ready of the core request.

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  ar_state_e         r_state;
  ar_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_araddr;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_run;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_gnt;

  assign w_ar_hs = (r_state == AR_PEND) && m_axi_arready;
  assign w_r_hs  = m_axi_rvalid && m_axi_rready;
  // r_run is cleared asynchronously by reset, so no grant is offered in reset.
  assign w_gnt   = r_run && instr_req_i && ((r_state == AR_IDLE) || w_ar_hs) &&
                   ((r_outstanding < MAX_CNT) || w_r_hs);

  assign instr_gnt_o       = w_gnt;
  assign instr_rvalid_o    = r_rvalid;
  assign instr_rdata_o     = r_rdata;
  assign instr_err_o       = r_err;
  assign m_axi_arvalid     = (r_state == AR_PEND);
  assign m_axi_araddr      = r_araddr;
  assign m_axi_arprot      = AXI_ARPROT_INSTR;
  assign m_axi_arlen       = AXI_LEN_SINGLE;
  assign m_axi_arsize      = AXI_SIZE_4B;
  assign m_axi_arburst     = AXI_BURST_INCR;
  assign m_axi_rready      = (r_outstanding != '0);
  assign dbg_ar_state_o    = r_state;
  assign dbg_outstanding_o = r_outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= AR_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AR_IDLE: if (w_gnt) w_state_nxt = AR_PEND;
      AR_PEND: begin
        if (w_gnt)              w_state_nxt = AR_PEND;
        else if (m_axi_arready) w_state_nxt = AR_IDLE;
      end
      default: w_state_nxt = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_araddr      <= '0;
      r_outstanding <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_gnt) r_araddr <= {instr_addr_i[ADDR_W-1:2], 2'b00};
      case ({w_gnt, w_r_hs})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_r_hs;
      r_err    <= w_r_hs && resp_is_err(m_axi_rresp);
      if (w_r_hs) r_rdata <= m_axi_rdata;
    end
  end

`ifdef KUUGA_FETCH_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              r_err_valid;
  logic [ADDR_W-1:0] r_err_addr;
  logic [1:0]        r_err_resp;
  logic              w_new_err;
  logic              w_unused;

  fetch_addr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ADDR_W)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_gnt),
    .i_wdata ({instr_addr_i[ADDR_W-1:2], 2'b00}),
    .i_pop   (w_r_hs),
    .o_rdata (w_head_addr),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_new_err = w_r_hs && resp_is_err(m_axi_rresp);

  // A clear in the same cycle as a new error re-arms capture for that error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_resp  <= '0;
    end else if (w_new_err && (!r_err_valid || err_clear_i)) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= w_head_addr;
      r_err_resp  <= m_axi_rresp;
    end else if (err_clear_i) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_resp_o  = r_err_resp;
  assign w_unused    = ^{w_fifo_full, w_fifo_empty, instr_addr_i[1:0], m_axi_rlast};
`else
  logic w_unused;

  assign err_valid_o = 1'b0;
  assign err_addr_o  = '0;
  assign err_resp_o  = '0;
  assign w_unused    = ^{err_clear_i, instr_addr_i[1:0], m_axi_rlast};
`endif

endmodule

// File: tb/tb_axi_instr_fetch_bridge.sv
// Self-checking bench for axi_instr_fetch_bridge: in-bench AXI slave plus a
// queue-based model of granted fetches, checked every cycle at negedge.
module tb_axi_instr_fetch_bridge;

  localparam int MAX_OUT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          clk;
  logic          rst_n;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_gnt_o;
  logic          instr_rvalid_o;
  logic [DW-1:0] instr_rdata_o;
  logic          instr_err_o;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [2:0]    m_axi_arprot;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          err_valid_o;
  logic [AW-1:0] err_addr_o;
  logic [1:0]    err_resp_o;
  logic          err_clear_i;
  logic          dbg_ar_state_o;
  logic [CW-1:0] dbg_outstanding_o;

  axi_instr_fetch_bridge #(
    .MAX_OUTSTANDING (MAX_OUT),
    .ADDR_W          (AW),
    .DATA_W          (DW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_req_i       (instr_req_i),
    .instr_addr_i      (instr_addr_i),
    .instr_gnt_o       (instr_gnt_o),
    .instr_rvalid_o    (instr_rvalid_o),
    .instr_rdata_o     (instr_rdata_o),
    .instr_err_o       (instr_err_o),
    .m_axi_araddr      (m_axi_araddr),
    .m_axi_arvalid     (m_axi_arvalid),
    .m_axi_arready     (m_axi_arready),
    .m_axi_arprot      (m_axi_arprot),
    .m_axi_arlen       (m_axi_arlen),
    .m_axi_arsize      (m_axi_arsize),
    .m_axi_arburst     (m_axi_arburst),
    .m_axi_rdata       (m_axi_rdata),
    .m_axi_rresp       (m_axi_rresp),
    .m_axi_rlast       (m_axi_rlast),
    .m_axi_rvalid      (m_axi_rvalid),
    .m_axi_rready      (m_axi_rready),
    .err_valid_o       (err_valid_o),
    .err_addr_o        (err_addr_o),
    .err_resp_o        (err_resp_o),
    .err_clear_i       (err_clear_i),
    .dbg_ar_state_o    (dbg_ar_state_o),
    .dbg_outstanding_o (dbg_outstanding_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus knobs
  bit          req_v;
  logic [31:0] addr_v;
  int          ar_stall;
  int          rdelay_v;
  bit          rand_mode;
  bit          spurious;
  bit          clr_v;

  // in-bench AXI slave
  logic [31:0] s_rq[$];
  int          s_rt[$];
  bit          r_hold;

  // model: granted-but-unanswered fetch addresses, in grant order
  logic [31:0] exp_q[$];
  bit          pend_ar;
  logic [31:0] pend_addr;
  bit          exp_rv;
  logic [31:0] exp_rd;
  bit          exp_err;
  bit          ev;
  logic [31:0] ea;
  logic [1:0]  er;

  int n_chk;
  int n_err;
  int cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80) return 32'hF81FF06F;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[11:8] == 4'h1) return a[2] ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_and_update();
    bit          exp_rready;
    bit          ar_hs;
    bit          r_hs;
    bit          exp_gnt;
    logic [31:0] a;
    exp_rready = (exp_q.size() != 0);
    ar_hs      = pend_ar && m_axi_arready;
    r_hs       = m_axi_rvalid && exp_rready;
    exp_gnt    = instr_req_i && (!pend_ar || ar_hs) && ((exp_q.size() < MAX_OUT) || r_hs);

    chk("gnt", instr_gnt_o, exp_gnt);
    chk("arvalid", m_axi_arvalid, pend_ar);
    chk("rready", m_axi_rready, exp_rready);
    if (pend_ar) begin
      chk("araddr", m_axi_araddr, pend_addr);
      chk("ar_consts", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot},
          {8'd0, 3'b010, 2'b01, 3'b100});
    end
    chk("rvalid_o", instr_rvalid_o, exp_rv);
    if (exp_rv) begin
      chk("rdata_o", instr_rdata_o, exp_rd);
      chk("err_o", instr_err_o, exp_err);
    end
`ifdef KUUGA_FETCH_ERR_CAPTURE_EN
    chk("err_valid", err_valid_o, ev);
    if (ev) begin
      chk("err_addr", err_addr_o, ea);
      chk("err_resp", err_resp_o, er);
    end
`else
    chk("err_tied", {err_valid_o, err_addr_o, err_resp_o}, 35'd0);
`endif

    exp_rv = r_hs;
    if (r_hs) begin
      a       = exp_q.pop_front();
      exp_rd  = mem_word(a);
      exp_err = resp_of(a)[1];
`ifdef KUUGA_FETCH_ERR_CAPTURE_EN
      if (exp_err && (!ev || err_clear_i)) begin
        ev = 1'b1;
        ea = a;
        er = resp_of(a);
      end else if (err_clear_i) ev = 1'b0;
    end else if (err_clear_i) begin
      ev = 1'b0;
`endif
    end
    if (ar_hs) pend_ar = 1'b0;
    if (exp_gnt) begin
      pend_ar   = 1'b1;
      pend_addr = {instr_addr_i[31:2], 2'b00};
      exp_q.push_back(pend_addr);
    end

    if (m_axi_rvalid && m_axi_rready && r_hold) begin
      void'(s_rq.pop_front());
      void'(s_rt.pop_front());
      r_hold = 1'b0;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      s_rq.push_back(m_axi_araddr);
      s_rt.push_back(cyc + 1 + rdelay_v);
    end
  endtask

  // driver: one clock cycle, inputs driven #1 after posedge, checked at negedge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_mode) begin
      req_v    = ($urandom_range(0, 9) < 7);
      addr_v   = $urandom & 32'h7FF;
      rdelay_v = $urandom_range(0, 4);
      clr_v    = ($urandom_range(0, 15) == 0);
    end
    if (ar_stall > 0) begin
      m_axi_arready = 1'b0;
      ar_stall--;
    end else if (rand_mode) m_axi_arready = ($urandom_range(0, 3) != 0);
    else m_axi_arready = 1'b1;
    if (!r_hold) begin
      if (s_rq.size() > 0 && s_rt[0] <= cyc) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(s_rq[0]);
        m_axi_rresp  = resp_of(s_rq[0]);
        m_axi_rlast  = 1'b1;
        r_hold       = 1'b1;
      end else if (spurious) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hDEADBEEF;
        m_axi_rresp  = 2'd0;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = $urandom_range(0, 1);
      end
    end
    instr_req_i  = req_v;
    instr_addr_i = addr_v;
    err_clear_i  = clr_v;
    @(negedge clk);
    check_and_update();
  endtask

  task automatic drain();
    int n;
    req_v = 1'b0;
    clr_v = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || pend_ar || exp_rv) && n < 300) begin
      step();
      n++;
    end
    chk("drain_bound", (n < 300), 1'b1);
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!instr_rvalid_o && n < 50);
    chk("rvalid_bound", (n < 50), 1'b1);
  endtask

  task automatic flush_model();
    exp_q.delete();
    s_rq.delete();
    s_rt.delete();
    pend_ar = 1'b0;
    exp_rv  = 1'b0;
    ev      = 1'b0;
    r_hold  = 1'b0;
  endtask

  initial begin
    int          idx;
    int          g;
    int          gnt_cyc[3];
    int          pulses;
    logic [31:0] b2b[3];
    b2b[0] = 32'h80; b2b[1] = 32'h84; b2b[2] = 32'h88;
    n_chk = 0; n_err = 0; cyc = 0;
    req_v = 0; addr_v = 0; ar_stall = 0; rdelay_v = 0;
    rand_mode = 0; spurious = 0; clr_v = 0;
    flush_model();
    rst_n = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h80;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = '0; m_axi_rlast = 1'b0; err_clear_i = 1'b0;

    // reset state, with a request pending to show the grant is held off
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", instr_gnt_o, 1'b0);
    chk("reset_outputs", {instr_rvalid_o, instr_rdata_o, instr_err_o, m_axi_arvalid,
                          m_axi_araddr, m_axi_rready}, 68'd0);
    chk("reset_err", {err_valid_o, err_addr_o, err_resp_o}, 35'd0);
    chk("reset_dbg", {dbg_ar_state_o, dbg_outstanding_o}, 0);
    instr_req_i = 1'b0;
    rst_n = 1'b1;
    step();

    // single fetch: grant N, arvalid N+1, rvalid_o N+3
    req_v = 1; addr_v = 32'h80;
    step();
    chk("single_gnt", instr_gnt_o, 1'b1);
    req_v = 0;
    step();
    chk("single_ar", {m_axi_arvalid, m_axi_araddr}, {1'b1, 32'h80});
    step();
    chk("single_n2_rvalid_o", instr_rvalid_o, 1'b0);
    step();
    chk("single_n3", {instr_rvalid_o, instr_rdata_o}, {1'b1, 32'hF81FF06F});
    pulses = 0;
    repeat (4) begin step(); if (instr_rvalid_o) pulses++; end
    chk("single_extra_pulse", pulses, 0);

    // back-to-back with slow R: third grant waits for the first R handshake
    rdelay_v = 5; req_v = 1; idx = 0; g = 0;
    while (idx < 3 && g < 40) begin
      addr_v = b2b[idx];
      step();
      if (instr_gnt_o) begin gnt_cyc[idx] = cyc; idx++; end
      g++;
    end
    chk("b2b_bound", idx, 3);
    chk("b2b_second_gnt", gnt_cyc[1] - gnt_cyc[0], 1);
    chk("b2b_third_gnt", gnt_cyc[2] - gnt_cyc[0], 7);
    drain();
    rdelay_v = 0;

    // AR backpressure: four stalled cycles, request for 0x204 waiting
    req_v = 1; addr_v = 32'h200;
    step();
    chk("bp_first_gnt", instr_gnt_o, 1'b1);
    addr_v = 32'h204; ar_stall = 4;
    repeat (4) begin
      step();
      chk("bp_stall", {instr_gnt_o, m_axi_arvalid, m_axi_araddr}, {2'b01, 32'h200});
    end
    step();
    chk("bp_release_gnt", instr_gnt_o, 1'b1);
    drain();

    // misaligned address is aligned down
    req_v = 1; addr_v = 32'h83;
    step();
    req_v = 0;
    step();
    chk("misaligned_araddr", m_axi_araddr, 32'h80);
    drain();

    // stray R beat with nothing outstanding is not accepted
    spurious = 1;
    step();
    chk("spurious_rready", m_axi_rready, 1'b0);
    spurious = 0;
    step();
    chk("spurious_no_rvalid_o", instr_rvalid_o, 1'b0);

    // error responses: SLVERR at 0x100, then DECERR at 0x104
    req_v = 1; addr_v = 32'h100;
    step();
    req_v = 0;
    wait_rvalid();
    chk("slverr_err_o", instr_err_o, 1'b1);
    drain();
    req_v = 1; addr_v = 32'h104;
    step();
    req_v = 0;
    wait_rvalid();
    chk("decerr_err_o", instr_err_o, 1'b1);
    drain();
    step();
`ifdef KUUGA_FETCH_ERR_CAPTURE_EN
    chk("sticky_err", {err_valid_o, err_addr_o, err_resp_o}, {1'b1, 32'h100, 2'd2});
    clr_v = 1;
    step();
    clr_v = 0;
    step();
    chk("err_cleared", err_valid_o, 1'b0);
`else
    chk("err_absent", err_valid_o, 1'b0);
`endif

    // randomized traffic
    rand_mode = 1;
    repeat (1500) step();
    rand_mode = 0;
    drain();

    // reset with two fetches in flight
    rdelay_v = 10; req_v = 1; addr_v = 32'h80;
    step();
    addr_v = 32'h84;
    step();
    addr_v = 32'h88;
    step();
    chk("pre_reset_outstanding", dbg_outstanding_o, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
                             m_axi_arvalid, m_axi_araddr, m_axi_rready}, 69'd0);
    chk("midreset_err", {err_valid_o, err_addr_o, err_resp_o}, 35'd0);
    flush_model();
    req_v = 0; instr_req_i = 1'b0; m_axi_rvalid = 1'b0; rdelay_v = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_v = 1; addr_v = 32'h80;
    step();
    chk("post_reset_gnt", instr_gnt_o, 1'b1);
    req_v = 0;
    wait_rvalid();
    chk("post_reset_rdata", instr_rdata_o, 32'hF81FF06F);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
